// File: rtl/trojan_sig_pkg.sv
`default_nettype none
// ============================================================================
// trojan_sig_pkg : shared FSM state type, default polynomials/seed, MISR step
// Rev 1.0
// ============================================================================
package trojan_sig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sig_state_t;

    localparam logic [15:0] SIG_POLY_DEF  = 16'h1021;
    localparam logic [15:0] LFSR_POLY_DEF = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // Left-shifting MISR: feedback from bit 15, response folded into bit 0.
    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic        din,
                                              input logic [15:0] poly);
        return {sig[14:0], 1'b0} ^ (sig[15] ? poly : 16'h0000) ^ {15'b0, din};
    endfunction

endpackage
`default_nettype wire

// File: rtl/trojan_lfsr_gen.sv
`default_nettype none
// ============================================================================
// trojan_lfsr_gen : right-shifting Galois LFSR stimulus source, load/advance
// Rev 1.0
// ============================================================================
module trojan_lfsr_gen
    import trojan_sig_pkg::*;
#(
    parameter int unsigned OUT_W = 1,
    parameter logic [15:0] SEED  = LFSR_SEED_DEF,
    parameter logic [15:0] POLY  = LFSR_POLY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    output logic [OUT_W-1:0] pattern
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? POLY : 16'h0000);
        end
    end

    assign pattern = r_lfsr[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/trojan_sig_compactor.sv
`default_nettype none
// ============================================================================
// trojan_sig_compactor : LFSR stimulus + MISR response compaction around a
// benchmark circuit. Optional golden compare: TROJAN_SIG_GOLDEN_CMP_EN.
// Rev 1.0
// ============================================================================
module trojan_sig_compactor
    import trojan_sig_pkg::*;
#(
    parameter int unsigned N_WIDTH     = 1,
    parameter int unsigned NUM_VECTORS = 2,
    parameter int unsigned DUT_LAT     = 1,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF,
    parameter logic [15:0] LFSR_POLY   = LFSR_POLY_DEF,
    parameter logic [15:0] SIG_POLY    = SIG_POLY_DEF,
    parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
    input  logic               CK,
    input  logic               reset,
    input  logic               start,
    output logic [N_WIDTH-1:0] n_out,
    input  logic               dut_out,
    output logic               busy,
    output logic               done,
    output logic [15:0]        vec_count,
    output logic [15:0]        signature,
    output logic               mismatch
);

    localparam logic [15:0] C_LAST = 16'(NUM_VECTORS - 1);

    sig_state_t         r_state;
    sig_state_t         w_state_next;
    logic [15:0]        r_issue_cnt;
    logic [15:0]        r_vec_count;
    logic [15:0]        r_sig;
    logic [15:0]        w_sig_next;
    logic [N_WIDTH-1:0] w_pattern;
    logic               w_start;
    logic               w_issue;
    logic               w_tok;
    logic               w_last_issue;
    logic               w_last_cap;

    assign w_start      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_issue      = (r_state == ST_RUN);
    assign w_last_issue = w_issue && (r_issue_cnt == C_LAST);
    assign w_last_cap   = w_tok && (r_vec_count == C_LAST);
    assign w_sig_next   = misr_step(r_sig, dut_out, SIG_POLY);

    trojan_lfsr_gen #(
        .OUT_W (N_WIDTH),
        .SEED  (LFSR_SEED),
        .POLY  (LFSR_POLY)
    ) u_lfsr (
        .clk     (CK),
        .rst     (reset),
        .load    (w_start),
        .advance (w_issue),
        .pattern (w_pattern)
    );

    // Each issued vector launches a token; its arrival marks the capture edge.
    generate
        if (DUT_LAT == 0) begin : g_lat0
            assign w_tok = w_issue;
        end else begin : g_latn
            logic [DUT_LAT-1:0] r_dl;
            always_ff @(posedge CK) begin
                if (reset || w_start) begin
                    r_dl <= '0;
                end else begin
                    r_dl <= (r_dl << 1) | DUT_LAT'(w_issue);
                end
            end
            assign w_tok = r_dl[DUT_LAT-1];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_last_cap) begin
                    w_state_next = ST_DONE;
                end else if (w_last_issue) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: if (w_last_cap) w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_issue_cnt <= 16'h0000;
            r_vec_count <= 16'h0000;
            r_sig       <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_issue_cnt <= 16'h0000;
                r_vec_count <= 16'h0000;
                r_sig       <= 16'h0000;
            end else begin
                if (w_issue) r_issue_cnt <= r_issue_cnt + 16'h0001;
                if (w_tok) begin
                    r_sig       <= w_sig_next;
                    r_vec_count <= r_vec_count + 16'h0001;
                end
            end
        end
    end

`ifdef TROJAN_SIG_GOLDEN_CMP_EN
    logic r_mismatch;
    // Every DONE entry coincides with the final capture, so w_sig_next is final.
    always_ff @(posedge CK) begin
        if (reset || w_start) begin
            r_mismatch <= 1'b0;
        end else if ((w_state_next == ST_DONE) && (r_state != ST_DONE)) begin
            r_mismatch <= (w_sig_next != GOLDEN_SIG);
        end
    end
    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

    assign n_out     = w_issue ? w_pattern : '0;
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign vec_count = r_vec_count;
    assign signature = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_trojan_sig_compactor.sv
`default_nettype none
// ============================================================================
// tb_trojan_sig_compactor : three parameterisations driven with random
// responses and checked against a spec-level run model.
// Rev 1.0
// ============================================================================
module tb_trojan_sig_compactor;

    logic              CK;
    logic              reset;
    logic              start;
    logic [2:0]        dout_v;
    logic              n0;
    logic [3:0]        n1;
    logic [2:0]        n2;
    logic [2:0]        busy_v;
    logic [2:0]        done_v;
    logic [2:0]        mm_v;
    logic [2:0][15:0]  vc_v;
    logic [2:0][15:0]  sig_v;

    int n_tests = 0;
    int n_fail  = 0;

    trojan_sig_compactor #(.GOLDEN_SIG(16'h0003)) dut0 (
        .CK(CK), .reset(reset), .start(start), .n_out(n0), .dut_out(dout_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .vec_count(vc_v[0]),
        .signature(sig_v[0]), .mismatch(mm_v[0]));

    trojan_sig_compactor #(.N_WIDTH(4), .NUM_VECTORS(37), .DUT_LAT(3),
                           .GOLDEN_SIG(16'h0000)) dut1 (
        .CK(CK), .reset(reset), .start(start), .n_out(n1), .dut_out(dout_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .vec_count(vc_v[1]),
        .signature(sig_v[1]), .mismatch(mm_v[1]));

    trojan_sig_compactor #(.N_WIDTH(3), .NUM_VECTORS(2), .DUT_LAT(0),
                           .GOLDEN_SIG(16'h1234)) dut2 (
        .CK(CK), .reset(reset), .start(start), .n_out(n2), .dut_out(dout_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .vec_count(vc_v[2]),
        .signature(sig_v[2]), .mismatch(mm_v[2]));

    initial CK = 1'b0;
    always #5 CK = ~CK;

    function automatic int nv_of(input int d);
        case (d) 0: return 2; 1: return 37; default: return 2; endcase
    endfunction
    function automatic int lat_of(input int d);
        case (d) 0: return 1; 1: return 3; default: return 0; endcase
    endfunction
    function automatic logic [15:0] mask_of(input int d);
        case (d) 0: return 16'h0001; 1: return 16'h000F; default: return 16'h0007; endcase
    endfunction
    function automatic logic [15:0] gold_of(input int d);
        case (d) 0: return 16'h0003; 1: return 16'h0000; default: return 16'h1234; endcase
    endfunction
    function automatic logic [15:0] nout_of(input int d);
        case (d) 0: return {15'b0, n0}; 1: return {12'b0, n1}; default: return {13'b0, n2}; endcase
    endfunction

    // k-th stimulus word straight from the LFSR recurrence.
    function automatic logic [15:0] lfsr_at(input int k);
        logic [15:0] x;
        x = 16'hACE1;
        for (int i = 0; i < k; i++) x = (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
        return x;
    endfunction

    function automatic logic [15:0] sig_step(input logic [15:0] s, input logic b);
        return 16'(s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
    endfunction

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Run model: per design, start edge and accumulated capture results.
    bit          m_act [3];
    int          m_s   [3];
    logic [15:0] m_sig [3];
    logic [15:0] m_vc  [3];
    logic        m_mm  [3];
    int          g_edge = 0;
    logic [2:0]  pat [0:63];

    task automatic model_edge(input int d, input logic sv, input logic rv, input logic din);
        int r;
        int fin;
        fin = nv_of(d) + lat_of(d);
        r   = g_edge - m_s[d];
        if (rv) begin
            m_act[d] = 0; m_sig[d] = 16'h0; m_vc[d] = 16'h0; m_mm[d] = 1'b0;
        end else begin
            if (m_act[d] && r >= 1 + lat_of(d) && r <= fin) begin
                m_sig[d] = sig_step(m_sig[d], din);
                m_vc[d]  = m_vc[d] + 16'h1;
`ifdef TROJAN_SIG_GOLDEN_CMP_EN
                if (r == fin) m_mm[d] = (m_sig[d] != gold_of(d));
`endif
            end
            if (sv && (!m_act[d] || r > fin)) begin
                m_act[d] = 1; m_s[d] = g_edge;
                m_sig[d] = 16'h0; m_vc[d] = 16'h0; m_mm[d] = 1'b0;
            end
        end
    endtask

    task automatic check_dut(input int d, input int e);
        int          r;
        logic        eb;
        logic        ed;
        logic [15:0] en;
        eb = 1'b0; ed = 1'b0; en = 16'h0;
        if (m_act[d]) begin
            r  = g_edge - m_s[d];
            eb = (r < nv_of(d) + lat_of(d));
            ed = !eb;
            if (r < nv_of(d)) en = lfsr_at(r) & mask_of(d);
        end
        check($sformatf("d%0d e%0d busy", d, e), {15'b0, busy_v[d]}, {15'b0, eb});
        check($sformatf("d%0d e%0d done", d, e), {15'b0, done_v[d]}, {15'b0, ed});
        check($sformatf("d%0d e%0d n_out", d, e), nout_of(d), en);
        check($sformatf("d%0d e%0d vec_count", d, e), vc_v[d], m_vc[d]);
        check($sformatf("d%0d e%0d signature", d, e), sig_v[d], m_sig[d]);
        check($sformatf("d%0d e%0d mismatch", d, e), {15'b0, mm_v[d]}, {15'b0, m_mm[d]});
    endtask

    // smode: 0 none, 1 pulse at e=0, 2 held; pmode: 0 zeros, 1 ones, 2 random, 3 replay
    task automatic run_seq(input int len, input int smode, input int rlo, input int rhi,
                           input int pmode);
        logic sv;
        logic rv;
        for (int e = 0; e < len; e++) begin
            sv = (smode == 1 && e == 0) || (smode == 2);
            rv = (e >= rlo && e <= rhi);
            if (pmode == 0)      pat[e] = 3'b000;
            else if (pmode == 1) pat[e] = 3'b111;
            else if (pmode == 2) pat[e] = 3'($urandom);
            start  = sv;
            reset  = rv;
            dout_v = pat[e];
            @(posedge CK);
            g_edge++;
            for (int d = 0; d < 3; d++) model_edge(d, sv, rv, pat[e][d]);
            @(negedge CK);
            for (int d = 0; d < 3; d++) check_dut(d, e);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_act[d] = 0; m_s[d] = 0; m_sig[d] = 16'h0; m_vc[d] = 16'h0; m_mm[d] = 1'b0;
        end
        start = 1'b0; reset = 1'b1; dout_v = 3'b000;
        run_seq(3, 0, 0, 2, 0);
        run_seq(45, 1, -1, -1, 0);
        run_seq(45, 1, -1, -1, 1);
        for (int i = 0; i < 3; i++) run_seq(45, 1, -1, -1, 2);
        run_seq(10, 1, 1, 1, 2);
        run_seq(45, 1, -1, -1, 3);
        run_seq(50, 2, -1, -1, 2);
        run_seq(45, 0, -1, -1, 2);
        run_seq(45, 1, -1, -1, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trojan_sig_compactor.md
# trojan_sig_compactor

Self-checking stimulus/response stage for the Benchmark_testing1000 trojan-detection flow. It sits around a benchmark circuit (`test_Ixxxx`): upstream it drives the circuit's `N` input from an LFSR pattern source, and downstream it consumes the circuit's single-bit output. It compacts the response stream into a MISR signature and can flag divergence from a golden signature, replacing the per-vector file dumps with an on-chip fingerprint.

## Interface
- `N_WIDTH`, 1: width of the stimulus bus driven to the benchmark `N` port.
- `NUM_VECTORS`, 2: vectors per run, range 1..65535.
- `DUT_LAT`, 1: edges between a vector being applied and its response being valid, range 0..4.
- `LFSR_SEED`, 16'hACE1: stimulus LFSR load value; must be non-zero.
- `LFSR_POLY`, 16'hB400: Galois taps for the stimulus LFSR, right-shifting.
- `SIG_POLY`, 16'h1021: MISR taps, left-shifting.
- `GOLDEN_SIG`, 16'h0000: expected signature.

Ports:
- `CK`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `n_out`  out  N_WIDTH  stimulus to the benchmark `N` port.
- `dut_out`  in  1  benchmark response (`output_single`).
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  high in DONE.
- `vec_count`  out  16  responses captured in the current or last run.
- `signature`  out  16  MISR contents.
- `mismatch`  out  1  signature differs from golden; see Configuration.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - When `start`=1: load the LFSR with `LFSR_SEED`, clear the MISR, `vec_count` and the issue counter, and go to RUN.
- **RUN**
  - `n_out` = `lfsr[N_WIDTH-1:0]`.
  - Every cycle: `lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_POLY : 0)`, the issue counter increments, and a valid token enters a DUT_LAT-deep delay line.
  - After NUM_VECTORS issues, go to DRAIN.
  - With DUT_LAT=0, go straight to DONE once the last capture occurs.
- **DRAIN**
  - `n_out` holds 0.
  - Go to DONE when the delay line is empty and the last capture has occurred.
- **Capture**
  - Happens whenever a delayed token is valid.
  - `sig <= (sig<<1) ^ (sig[15] ? SIG_POLY : 0) ^ {15'b0, dut_out}`.
  - `vec_count` increments on each capture.
  - With DUT_LAT=0, capture samples `dut_out` on the same edge that ends the vector's cycle.
- **DONE**
  - `done`=1; `signature` and `vec_count` are held.
  - `start`=1 restarts exactly as from IDLE.
- Outside RUN, `n_out` is 0.
- `start` in RUN or DRAIN is ignored.
- All arithmetic is unsigned. Counters are 16 bits and never wrap within a legal run.
- Reset values: state IDLE, `n_out`=0, `busy`=0, `done`=0, `vec_count`=0, `signature`=0, `mismatch`=0, LFSR=`LFSR_SEED`, delay line cleared.
- Reset mid-run overrides everything: return to IDLE at that edge and discard in-flight tokens.

## Timing
- Timing is counted from E0, the edge at which `start` is sampled.
- Vector k (0-based) is driven during the cycle between E(k) and E(k+1).
- The response to vector k is captured at E(k+1+DUT_LAT).
- `done` registers high at E(NUM_VECTORS+DUT_LAT) and `busy` falls at that same edge.
- Defaults: `done` is high after 3 edges, and the vector sequence is 1, 0.
- `mismatch` is registered and updates on the edge DONE is entered, so it is valid in the same cycle `done` first reads 1.

## Configuration
- Macro: `TROJAN_SIG_GOLDEN_CMP_EN`.
- Defined: `mismatch` = (`signature` != `GOLDEN_SIG`), registered on DONE entry and held until the next start or reset.
- Undefined: the comparator is not built, `mismatch` is tied 0, and `GOLDEN_SIG` is unused.

## Structure
- Shared package `trojan_sig_pkg`:
  - state enum `sig_state_t`;
  - default constants `SIG_POLY_DEF`, `LFSR_POLY_DEF`, `LFSR_SEED_DEF`;
  - function `misr_step(sig, bit)`.
- One sub-module, `trojan_lfsr_gen`, holding the stimulus LFSR with load/advance controls.
- The FSM, delay line, MISR and compare stay in the top module.

## Test plan
- Defaults, `dut_out` tied 0, start pulse → `n_out` 1 then 0; `done` after 3 edges; `signature`=16'h0000; `vec_count`=2.
- Defaults, `dut_out` tied 1 → `signature`=16'h0003; with the macro on and GOLDEN_SIG=16'h0003, `mismatch`=0; with GOLDEN_SIG=16'h0000, `mismatch`=1.
- DUT_LAT=0, NUM_VECTORS=2 → `done` after 2 edges; no DRAIN cycle.
- `reset` asserted at E1 of a run → IDLE next cycle; all outputs return to reset values; a fresh start reproduces the same signature.
- `start` held high through RUN/DRAIN → a single run; held into DONE → an immediate restart, with `busy` rising on the edge after `done`.
- Macro undefined, `dut_out` tied 1, GOLDEN_SIG=16'h0000 → `mismatch` stays 0.
